// File: rtl/pio_input_conditioner_pkg.sv
// Shared types and sizing helpers for the PIO input conditioner.
package pio_input_conditioner_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } db_state_e;

    // Settle counter width; wide enough to hold DEBOUNCE_CYCLES-1.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One-bit conditioner: 2-flop synchronizer, settle FSM with counter, and
// edge pulses that coincide with the clean level update.
module debounce_bit
    import pio_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic commit
);

    localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    db_state_e     state;
    logic [CW-1:0] cnt;

    // High on the edge where the clean level is about to take the new value.
    assign commit = (state == SETTLING) && (sync2 != clean) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            state <= STABLE;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            case (state)
                STABLE: begin
                    cnt <= '0;
                    if (sync2 != clean)
                        state <= SETTLING;
                end
                SETTLING: begin
                    if (sync2 == clean) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        clean <= sync2;
                        rise  <= sync2;
                        fall  <= ~sync2;
                        state <= STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pio_input_conditioner.sv
// Debounces WIDTH switch/key inputs for a PIO in_port and flags level edges.
module pio_input_conditioner
    import pio_input_conditioner_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] commit;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (raw_in[i]),
            .clean  (clean_out[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .commit (commit[i])
        );
    end

    // Built from the per-bit commit strobes so it lines up with rise/fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            changed <= 1'b0;
        else
            changed <= |commit;
    end

endmodule

// File: tb/tb_pio_input_conditioner.sv
// Scoreboard bench for pio_input_conditioner with DEBOUNCE_CYCLES=4, WIDTH=8.
module tb_pio_input_conditioner;

    localparam int W   = 8;
    localparam int DC  = 4;
    localparam int LAT = DC + 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] clean_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int           cyc;
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] prev_clean = '0;

    pio_input_conditioner #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw_in   (raw_in),
        .clean_out(clean_out),
        .rise     (rise),
        .fall     (fall),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive raw_in just after a falling edge; the next rising edge samples it.
    task automatic drive(input logic [W-1:0] v, output int c);
        @(negedge clk);
        raw_in = v;
        c = cyc;
    endtask

    task automatic expect_event(input int c, input logic [W-1:0] cl,
                                input logic [W-1:0] r, input logic [W-1:0] f);
        exp_t e;
        e.cyc = c + LAT;
        e.clean = cl;
        e.rise = r;
        e.fall = f;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every changed pulse pops one expected event; outside events
    // the outputs must hold still and pulses must stay low.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prev_clean = '0;
        end else begin
            if (changed) begin
                if (q.size() == 0) begin
                    check("unexpected_event", int'(clean_out), int'(prev_clean));
                    check("unexpected_changed", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_clean", int'(clean_out), int'(e.clean));
                    check("event_rise", int'(rise), int'(e.rise));
                    check("event_fall", int'(fall), int'(e.fall));
                end
            end else if (rise != '0 || fall != '0 || clean_out != prev_clean) begin
                fails++;
                tests++;
                $display("FAIL quiet_cycle: clean=0x%0h rise=0x%0h fall=0x%0h expected clean=0x%0h rise=0 fall=0 (cycle %0d)",
                         clean_out, rise, fall, prev_clean, cyc);
            end
            if ((rise & fall) != '0) begin
                fails++;
                tests++;
                $display("FAIL rise_and_fall: rise=0x%0h fall=0x%0h expected disjoint", rise, fall);
            end
            prev_clean = clean_out;
        end
    end

    initial begin
        int c;

        // Reset state
        idle(3);
        check("reset_clean", int'(clean_out), 0);
        check("reset_rise", int'(rise), 0);
        check("reset_fall", int'(fall), 0);
        check("reset_changed", int'(changed), 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        idle(3);

        // Single bit rises and is held
        drive(8'h01, c);
        expect_event(c, 8'h01, 8'h01, 8'h00);
        idle(12);

        // Return low, then a 3-cycle pulse that must be rejected
        drive(8'h00, c);
        expect_event(c, 8'h00, 8'h00, 8'h01);
        idle(12);
        drive(8'h01, c);
        idle(2);
        drive(8'h00, c);
        idle(12);
        check("glitch_clean", int'(clean_out), 0);

        // Several bits together, both directions
        drive(8'hA5, c);
        expect_event(c, 8'hA5, 8'hA5, 8'h00);
        idle(12);
        drive(8'h00, c);
        expect_event(c, 8'h00, 8'h00, 8'hA5);
        idle(12);

        // Bit3 bounces, latency counted from the last transition
        drive(8'h08, c);
        drive(8'h00, c);
        drive(8'h08, c);
        drive(8'h00, c);
        drive(8'h08, c);
        expect_event(c, 8'h08, 8'h08, 8'h00);
        idle(12);
        drive(8'h00, c);
        expect_event(c, 8'h00, 8'h00, 8'h08);
        idle(12);

        // Reset mid-settling on bit2, then a normal debounce after release
        drive(8'h04, c);
        idle(4);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_clean", int'(clean_out), 0);
        check("midreset_rise", int'(rise), 0);
        check("midreset_fall", int'(fall), 0);
        check("midreset_changed", int'(changed), 0);
        idle(2);
        @(negedge clk);
        #2 reset_n = 1'b1;
        c = cyc;
        expect_event(c, 8'h04, 8'h04, 8'h00);
        idle(14);
        check("post_reset_clean", int'(clean_out), 8'h04);

        check("events_pending", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
